bidi_half_duplex_ctrl: RTL and testbench

Sequences one single-ended bidirectional pad buffer as a half-duplex, single-wire serial link.
- Transmit: drives 8N1 frames on request, then releases the pad after a turnaround hold.
- Receive: listens with the pad tri-stated and decodes inbound 8N1 frames.
- Connects directly to the pad buffer's I/T/O pins and arbitrates the one wire between the local transmitter and the remote talker.

---
 rtl/bidi_half_duplex_ctrl_if.sv | 30 +++
 rtl/bidi_half_duplex_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bidi_half_duplex_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bidi_half_duplex_ctrl_if.sv
// rtl/bidi_half_duplex_ctrl_if.sv - host and pad buffer signal bundle for bidi_half_duplex_ctrl
//
// tx_req/tx_data   : host -> controller, level request and byte to send
// tx_busy/tx_done  : controller -> host, transmit status
// rx_data/rx_valid/rx_err : controller -> host, receive result and pulses
// pad_i/pad_t      : controller -> pad buffer drive value and tri-state (1 = released)
// pad_o            : pad buffer -> controller readback (asynchronous)
// modport slave is the controller, modport master is the host/pad side.
interface bidi_half_duplex_ctrl_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       pad_i;
  logic       pad_t;
  logic       pad_o;

  modport master (
    output tx_req, tx_data, pad_o,
    input  tx_busy, tx_done, rx_data, rx_valid, rx_err, pad_i, pad_t
  );

  modport slave (
    input  tx_req, tx_data, pad_o,
    output tx_busy, tx_done, rx_data, rx_valid, rx_err, pad_i, pad_t
  );
endinterface

// File: rtl/bidi_half_duplex_ctrl.sv
// rtl/bidi_half_duplex_ctrl.sv - half-duplex 8N1 single-wire link sequencer for one bidirectional pad
//
// clk     : system clock, rising edge
// reset_n : asynchronous active-low reset
// bus     : slave side of bidi_half_duplex_ctrl_if (host tx/rx handshake and pad I/T/O)
module bidi_half_duplex_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TURN_CLKS    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  bidi_half_duplex_ctrl_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + TURN_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);
  localparam logic [CW-1:0] TURN_END  = CW'(TURN_CLKS);

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_TURN, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          pad_meta, pad_s, pad_s_d;
  logic          pad_i_q, pad_t_q, tx_busy_q, tx_done_q, rx_valid_q, rx_err_q;
  logic [7:0]    rx_data_q;
  logic          start_edge;

  // pad_s_d follows pad_s every cycle, so on re-entering IDLE it already
  // holds the current line level and the driven-high tail never looks like
  // a falling edge.
  assign start_edge = pad_s_d & ~pad_s;

  assign bus.pad_i    = pad_i_q;
  assign bus.pad_t    = pad_t_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;

  // Pad outputs are registered one edge behind the state entry, so the
  // accept edge leaves the pad released and the turnaround state owns one
  // extra edge on which it releases the pad and pulses tx_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pad_meta   <= 1'b1;
      pad_s      <= 1'b1;
      pad_s_d    <= 1'b1;
      pad_i_q    <= 1'b1;
      pad_t_q    <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      pad_meta   <= bus.pad_o;
      pad_s      <= pad_meta;
      pad_s_d    <= pad_s;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          pad_t_q   <= 1'b1;
          pad_i_q   <= 1'b1;
          tx_busy_q <= 1'b0;
          cnt       <= '0;
          bit_idx   <= '0;
          if (start_edge) begin
            state <= RX_START;
          end else if (bus.tx_req) begin
            shift     <= bus.tx_data;
            tx_busy_q <= 1'b1;
            state     <= TX_START;
          end
        end
        TX_START: begin
          pad_t_q <= 1'b0;
          pad_i_q <= 1'b0;
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= TX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_DATA: begin
          pad_t_q <= 1'b0;
          pad_i_q <= shift[0];
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= TX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_STOP: begin
          pad_t_q <= 1'b0;
          pad_i_q <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= TX_TURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_TURN: begin
          pad_i_q <= 1'b1;
          if (cnt == TURN_END) begin
            pad_t_q   <= 1'b1;
            tx_done_q <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            pad_t_q <= 1'b0;
            cnt     <= cnt + 1'b1;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= pad_s ? IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {pad_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            rx_data_q  <= shift;
            rx_valid_q <= pad_s;
            rx_err_q   <= ~pad_s;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bidi_half_duplex_ctrl.sv
// tb/tb_bidi_half_duplex_ctrl.sv - scoreboard bench for bidi_half_duplex_ctrl
module tb_bidi_half_duplex_ctrl;

  localparam int CPB  = 16;
  localparam int TURN = 4;
  localparam int TX_LOW  = 10 * CPB + TURN;
  localparam int TX_BUSY = TX_LOW + 2;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       remote;
  logic       rx_window;

  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;
  int n_overlap = 0;
  int n_contention = 0;
  int low_cnt = 0;
  int bad_bits = 0;
  int busy_cnt = 0;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] cur_tx;
  logic [9:0] frame;
  logic       exp_bit;

  bidi_half_duplex_ctrl_if bus ();

  assign bus.tx_req  = tx_req;
  assign bus.tx_data = tx_data;
  assign bus.pad_o   = bus.pad_t ? remote : bus.pad_i;

  bidi_half_duplex_ctrl #(.CLKS_PER_BIT(CPB), .TURN_CLKS(TURN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      low_cnt  = 0;
      bad_bits = 0;
      busy_cnt = 0;
    end else begin
      if (!bus.pad_t) begin
        if (low_cnt == 0) begin
          if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
          else cur_tx = tx_q[0];
        end
        frame   = {1'b1, cur_tx, 1'b0};
        exp_bit = (low_cnt < 10 * CPB) ? frame[low_cnt / CPB] : 1'b1;
        if (bus.pad_i !== exp_bit) bad_bits++;
        if (rx_window) n_contention++;
        low_cnt++;
      end else if (low_cnt != 0) begin
        check("tx_len", low_cnt, TX_LOW);
        check("tx_bits", bad_bits, 0);
        check("tx_done_on_release", bus.tx_done, 1);
        if (tx_q.size() != 0) void'(tx_q.pop_front());
        low_cnt  = 0;
        bad_bits = 0;
      end
      if (bus.tx_busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        check("tx_busy_len", busy_cnt, TX_BUSY);
        busy_cnt = 0;
      end
      if (bus.tx_done) n_done++;
      if (bus.tx_done && (bus.rx_valid || bus.rx_err)) n_overlap++;
      if (bus.rx_valid && bus.rx_err) n_overlap++;
      if (bus.rx_valid || bus.rx_err) begin
        rx_window = 1'b0;
        if (rx_q.size() == 0) begin
          check("rx_unexpected", 1, 0);
        end else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          check("rx_err_flag", bus.rx_err, e.err);
          check("rx_valid_flag", bus.rx_valid, !e.err);
          check("rx_data", bus.rx_data, e.data);
        end
      end
    end
  end

  task automatic hold_bit(input logic b);
    remote = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_exp_t e;
    e.err  = !stop;
    e.data = d;
    rx_q.push_back(e);
    @(posedge clk);
    #1;
    rx_window = 1'b1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    hold_bit(stop);
    remote = 1'b1;
  endtask

  task automatic wait_tx_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        seen   = 1;
        tx_req = 1'b0;
      end
    end
    if (!seen) begin
      check("tx_done_timeout", 0, 1);
      tx_req = 1'b0;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_req    = 1'b0;
    tx_data   = 8'h00;
    remote    = 1'b1;
    rx_window = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pad_t", bus.pad_t, 1);
    check("rst_pad_i", bus.pad_i, 1);
    check("rst_tx_busy", bus.tx_busy, 0);
    check("rst_tx_done", bus.tx_done, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_err", bus.rx_err, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // transmit A5
    tx_data = 8'hA5;
    tx_q.push_back(8'hA5);
    tx_req = 1'b1;
    wait_tx_done(400);
    repeat (10) @(negedge clk);

    // receive 3C, framing error 81, glitch then 55
    send_frame(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    send_frame(8'h81, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    remote = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    remote = 1'b1;
    repeat (30) @(posedge clk);
    send_frame(8'h55, 1'b1);
    repeat (20) @(posedge clk);

    // tx_req arrives in the same cycle the start edge is detected
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        tx_data = 8'h96;
        tx_q.push_back(8'h96);
        tx_req = 1'b1;
      end
    join
    wait_tx_done(600);
    repeat (10) @(negedge clk);

    // reset in the middle of the data bits, request held
    tx_data = 8'h3B;
    tx_q.push_back(8'h3B);
    tx_req = 1'b1;
    begin
      bit fell = 0;
      for (int i = 0; i < 50 && !fell; i++) begin
        @(negedge clk);
        if (!bus.pad_t) fell = 1;
      end
      check("tx_start_seen", fell, 1);
    end
    repeat (40) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_pad_t", bus.pad_t, 1);
    check("async_rst_pad_i", bus.pad_i, 1);
    check("async_rst_busy", bus.tx_busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_tx_done(400);
    repeat (20) @(negedge clk);

    check("tx_done_pulses", n_done, 3);
    check("pulse_overlap", n_overlap, 0);
    check("pad_driven_during_rx", n_contention, 0);
    check("rx_q_left", rx_q.size(), 0);
    check("tx_q_left", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
